brush_stroke_ctrl: RTL and testbench

//  Sequences all brush-side writes into the 256x256x12 VRAM canvas. Owns the cursor:

---
 rtl/brush_stroke_ctrl.sv | 130 +++++++++++++
 tb/tb_brush_stroke_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/brush_stroke_ctrl.sv
// Brush-side VRAM write sequencer: steps the cursor from the board buttons with
// hold-to-accelerate, and stamps a square brush around the cursor one pixel per cycle.
module brush_stroke_ctrl #(
    parameter int ACCEL_HOLD = 4,
    parameter int FAST_STEP  = 4
) (
    input  logic        CLK10HZ,
    input  logic        reset,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        draw,
    input  logic [1:0]  brush_size,
    input  logic [11:0] brush_colour,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y,
    output logic        wr_en,
    output logic [7:0]  wr_x,
    output logic [7:0]  wr_y,
    output logic [11:0] wr_colour,
    output logic        busy
);

    localparam int HW = (ACCEL_HOLD < 1) ? 1 : $clog2(ACCEL_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(ACCEL_HOLD);
    localparam logic [7:0]    FAST_STEP8 = 8'(FAST_STEP);

    typedef enum logic {IDLE, STAMP} state_t;

    state_t             state;
    logic [HW-1:0]      hold_cnt;
    logic               stamp_valid;
    logic [15:0]        last_stamp;
    logic [7:0]         cx, cy;
    logic [1:0]         r;
    logic [11:0]        col;
    logic signed [3:0]  dx, dy;

    // Offsets span -3..+3 around a 0..255 centre, so 10-bit signed sums never overflow.
    logic signed [9:0]  sum_x, sum_y;
    logic signed [3:0]  r_s;
    logic               in_range;
    logic               any_btn;
    logic               start;
    logic [7:0]         step;

    assign r_s      = $signed({2'b00, r});
    assign sum_x    = $signed({2'b00, cx}) + $signed({{6{dx[3]}}, dx});
    assign sum_y    = $signed({2'b00, cy}) + $signed({{6{dy[3]}}, dy});
    assign in_range = (sum_x[9:8] == 2'b00) && (sum_y[9:8] == 2'b00);
    assign any_btn  = BTNU | BTND | BTNL | BTNR;
    assign start    = draw && (!stamp_valid || ({cursor_x, cursor_y} != last_stamp));
    assign step     = (hold_cnt == HOLD_MAX) ? FAST_STEP8 : 8'd1;
    assign busy     = (state == STAMP);

    // Opposing buttons cancel; 8-bit arithmetic wraps the cursor around the canvas.
    function automatic logic [7:0] move(input logic [7:0] pos, input logic dec,
                                        input logic inc, input logic [7:0] amt);
        case ({dec, inc})
            2'b10:   return pos - amt;
            2'b01:   return pos + amt;
            default: return pos;
        endcase
    endfunction

    // NOTE: all state here is updated with <= so every branch sees pre-edge values.
    always_ff @(posedge CLK10HZ or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cursor_x    <= 8'd128;
            cursor_y    <= 8'd128;
            hold_cnt    <= '0;
            stamp_valid <= 1'b0;
            last_stamp  <= '0;
            cx          <= '0;
            cy          <= '0;
            r           <= '0;
            col         <= '0;
            dx          <= '0;
            dy          <= '0;
            wr_en       <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_colour   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (start) begin
                        state <= STAMP;
                        cx    <= cursor_x;
                        cy    <= cursor_y;
                        r     <= brush_size;
                        col   <= brush_colour;
                        dx    <= -$signed({2'b00, brush_size});
                        dy    <= -$signed({2'b00, brush_size});
                    end else begin
                        cursor_x <= move(cursor_x, BTNL, BTNR, step);
                        cursor_y <= move(cursor_y, BTNU, BTND, step);
                        if (!any_btn)
                            hold_cnt <= '0;
                        else if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                STAMP: begin
                    wr_x      <= sum_x[7:0];
                    wr_y      <= sum_y[7:0];
                    wr_colour <= col;
                    wr_en     <= in_range;
                    if (dx == r_s) begin
                        dx <= -r_s;
                        if (dy == r_s) begin
                            state       <= IDLE;
                            last_stamp  <= {cx, cy};
                            stamp_valid <= 1'b1;
                        end else begin
                            dy <= dy + 4'sd1;
                        end
                    end else begin
                        dx <= dx + 4'sd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brush_stroke_ctrl.sv
// Scoreboard bench for brush_stroke_ctrl: stimulus pushes expected VRAM writes,
// a negedge monitor pops and compares every wr_en pulse.
module tb_brush_stroke_ctrl;

    logic        CLK10HZ;
    logic        reset;
    logic        BTNU, BTND, BTNL, BTNR;
    logic        draw;
    logic [1:0]  brush_size;
    logic [11:0] brush_colour;
    logic [7:0]  cursor_x, cursor_y;
    logic        wr_en;
    logic [7:0]  wr_x, wr_y;
    logic [11:0] wr_colour;
    logic        busy;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  writes = 0;

    brush_stroke_ctrl #(.ACCEL_HOLD(4), .FAST_STEP(4)) dut (
        .CLK10HZ     (CLK10HZ),
        .reset       (reset),
        .BTNU        (BTNU),
        .BTND        (BTND),
        .BTNL        (BTNL),
        .BTNR        (BTNR),
        .draw        (draw),
        .brush_size  (brush_size),
        .brush_colour(brush_colour),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_colour   (wr_colour),
        .busy        (busy)
    );

    initial CLK10HZ = 1'b0;
    always #5 CLK10HZ = ~CLK10HZ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
        wr_t e;
        e.x = x;
        e.y = y;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge CLK10HZ);
        reset = 1'b0;
        @(negedge CLK10HZ);
    endtask

    task automatic btn_pulse(input logic [3:0] b);
        {BTNU, BTND, BTNL, BTNR} = b;
        @(negedge CLK10HZ);
        {BTNU, BTND, BTNL, BTNR} = 4'b0000;
        @(negedge CLK10HZ);
    endtask

    // Monitor: every visible write must match the head of the scoreboard.
    always @(negedge CLK10HZ) begin
        if (wr_en === 1'b1) begin
            wr_t e;
            writes++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got (%0d,%0d,%0h) expected none",
                         wr_x, wr_y, wr_colour);
            end else begin
                e = exp_q.pop_front();
                check("wr_x", 32'(wr_x), 32'(e.x));
                check("wr_y", 32'(wr_y), 32'(e.y));
                check("wr_colour", 32'(wr_colour), 32'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int n;
        int xs[6] = '{129, 130, 131, 132, 136, 140};

        reset = 1'b1;
        {BTNU, BTND, BTNL, BTNR} = 4'b0000;
        draw = 1'b0;
        brush_size = 2'd0;
        brush_colour = 12'h000;
        repeat (2) @(negedge CLK10HZ);
        reset = 1'b0;
        @(negedge CLK10HZ);

        // 1) reset state
        check("rst_cursor_x", 32'(cursor_x), 32'd128);
        check("rst_cursor_y", 32'(cursor_y), 32'd128);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_x", 32'(wr_x), 32'd0);
        check("rst_wr_colour", 32'(wr_colour), 32'd0);

        // 2) 1x1 stamp, draw held: exactly one write
        brush_colour = 12'hF00;
        push(8'd128, 8'd128, 12'hF00);
        w0 = writes;
        draw = 1'b1;
        repeat (10) @(negedge CLK10HZ);
        draw = 1'b0;
        repeat (3) @(negedge CLK10HZ);
        check("t2_write_count", 32'(writes - w0), 32'd1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3) move to (0,0) with acceleration: 4 x 1 + 31 x 4 = 128
        {BTNU, BTND, BTNL, BTNR} = 4'b1010;
        repeat (35) @(negedge CLK10HZ);
        {BTNU, BTND, BTNL, BTNR} = 4'b0000;
        @(negedge CLK10HZ);
        check("t3_cursor_x", 32'(cursor_x), 32'd0);
        check("t3_cursor_y", 32'(cursor_y), 32'd0);

        brush_size = 2'd1;
        brush_colour = 12'h0F0;
        push(8'd0, 8'd0, 12'h0F0);
        push(8'd1, 8'd0, 12'h0F0);
        push(8'd0, 8'd1, 12'h0F0);
        push(8'd1, 8'd1, 12'h0F0);
        w0 = writes;
        draw = 1'b1;
        @(negedge CLK10HZ);
        draw = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge CLK10HZ);
        end
        repeat (2) @(negedge CLK10HZ);
        check("t3_busy_cycles", 32'(n), 32'd9);
        check("t3_write_count", 32'(writes - w0), 32'd4);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4) BTNR held: acceleration after 4 held cycles, restart after release
        pulse_reset();
        BTNR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK10HZ);
            check($sformatf("t4_x_step%0d", i), 32'(cursor_x), 32'(xs[i]));
        end
        BTNR = 1'b0;
        @(negedge CLK10HZ);
        check("t4_x_released", 32'(cursor_x), 32'd140);
        BTNR = 1'b1;
        @(negedge CLK10HZ);
        check("t4_x_restart1", 32'(cursor_x), 32'd141);
        @(negedge CLK10HZ);
        check("t4_x_restart2", 32'(cursor_x), 32'd142);
        BTNR = 1'b0;
        @(negedge CLK10HZ);
        check("t4_y_unchanged", 32'(cursor_y), 32'd128);

        // 5) wrap at the canvas edge, opposing buttons cancel
        pulse_reset();
        BTNR = 1'b1;
        repeat (34) @(negedge CLK10HZ);
        BTNR = 1'b0;
        @(negedge CLK10HZ);
        check("t5_x_252", 32'(cursor_x), 32'd252);
        repeat (3) btn_pulse(4'b0001);
        check("t5_x_255", 32'(cursor_x), 32'd255);
        btn_pulse(4'b0001);
        check("t5_x_wrap0", 32'(cursor_x), 32'd0);
        {BTNL, BTNR} = 2'b11;
        repeat (3) @(negedge CLK10HZ);
        {BTNL, BTNR} = 2'b00;
        @(negedge CLK10HZ);
        check("t5_x_lr_cancel", 32'(cursor_x), 32'd0);
        btn_pulse(4'b0010);
        check("t5_x_wrap255", 32'(cursor_x), 32'd255);
        btn_pulse(4'b1000);
        check("t5_y_up", 32'(cursor_y), 32'd127);

        // 6) reset aborts a 7x7 stamp after two writes, then re-stamp
        pulse_reset();
        brush_size = 2'd3;
        brush_colour = 12'hABC;
        push(8'd125, 8'd125, 12'hABC);
        push(8'd126, 8'd125, 12'hABC);
        w0 = writes;
        draw = 1'b1;
        repeat (3) @(negedge CLK10HZ);
        #2 reset = 1'b1;
        #1;
        check("t6_abort_wr_en", 32'(wr_en), 32'd0);
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_cursor_x", 32'(cursor_x), 32'd128);
        check("t6_abort_cursor_y", 32'(cursor_y), 32'd128);
        check("t6_writes_before_abort", 32'(writes - w0), 32'd2);
        brush_size = 2'd0;
        brush_colour = 12'h123;
        push(8'd128, 8'd128, 12'h123);
        @(negedge CLK10HZ);
        reset = 1'b0;
        repeat (4) @(negedge CLK10HZ);
        draw = 1'b0;
        repeat (2) @(negedge CLK10HZ);
        check("t6_write_count", 32'(writes - w0), 32'd3);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
